// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one data memory between the load/store unit (port 0)
// and the DMA/debug master (port 1), with alignment/range checking and buffered responses.
module data_mem_arbiter #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        P0_ReqValid,
    output logic        P0_ReqReady,
    input  logic [31:0] P0_ReqAddr,
    input  logic [2:0]  P0_ReqOp,
    input  logic        P0_ReqWrEn,
    input  logic [31:0] P0_ReqData,
    output logic        P0_RspValid,
    input  logic        P0_RspReady,
    output logic [31:0] P0_RspData,
    output logic        P0_RspErr,
    input  logic        P1_ReqValid,
    output logic        P1_ReqReady,
    input  logic [31:0] P1_ReqAddr,
    input  logic [2:0]  P1_ReqOp,
    input  logic        P1_ReqWrEn,
    input  logic [31:0] P1_ReqData,
    output logic        P1_RspValid,
    input  logic        P1_RspReady,
    output logic [31:0] P1_RspData,
    output logic        P1_RspErr,
    output logic [31:0] Mem_Addr,
    output logic [2:0]  Mem_MemOp,
    output logic [31:0] Mem_DataIn,
    output logic        Mem_WrEn,
    input  logic [31:0] Mem_DataOut,
    output logic        Busy
);

    // state   | meaning
    // IDLE    | arbitrating, ReqReady may be high
    // ISSUE   | Mem_* driven, memory writes on falling edge / reads on closing edge
    // CAPTURE | memory read data valid, latched into the response buffer
    // RESP    | response shown on the owning port until its RspReady
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam logic [31:0] DepthWords = MEM_DEPTH;

    state_t      state;
    logic        lastGrant;
    logic        owner;
    logic        curWrEn;
    logic        rspValid;
    logic        rspErr;
    logic [31:0] rspData;

    logic        isIdle;
    logic        selPort;
    logic        accept;
    logic [31:0] selAddr;
    logic [2:0]  selOp;
    logic        selWrEn;
    logic [31:0] selData;
    logic        selIllegal;

    function automatic logic isIllegal(input logic [31:0] addr, input logic [2:0] op);
        logic bad;
        case (op)
            3'b000, 3'b010: bad = (addr[1:0] != 2'b00);
            3'b001, 3'b101: bad = addr[0];
            3'b100:         bad = 1'b0;
            default:        bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= DepthWords) bad = 1'b1;
        return bad;
    endfunction

    // On a tie the port that did not win last time is granted.
    assign isIdle      = (state == IDLE);
    assign P0_ReqReady = isIdle && P0_ReqValid && (!P1_ReqValid || lastGrant);
    assign P1_ReqReady = isIdle && P1_ReqValid && (!P0_ReqValid || !lastGrant);
    assign accept      = P0_ReqReady || P1_ReqReady;
    assign selPort     = P1_ReqReady;

    assign selAddr    = selPort ? P1_ReqAddr : P0_ReqAddr;
    assign selOp      = selPort ? P1_ReqOp   : P0_ReqOp;
    assign selWrEn    = selPort ? P1_ReqWrEn : P0_ReqWrEn;
    assign selData    = selPort ? P1_ReqData : P0_ReqData;
    assign selIllegal = isIllegal(selAddr, selOp);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            lastGrant  <= 1'b1;
            owner      <= 1'b0;
            curWrEn    <= 1'b0;
            rspValid   <= 1'b0;
            rspErr     <= 1'b0;
            rspData    <= '0;
            Mem_Addr   <= '0;
            Mem_MemOp  <= '0;
            Mem_DataIn <= '0;
            Mem_WrEn   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lastGrant <= selPort;
                        owner     <= selPort;
                        curWrEn   <= selWrEn;
                        if (selIllegal) begin
                            rspErr   <= 1'b1;
                            rspData  <= '0;
                            rspValid <= 1'b1;
                            state    <= RESP;
                        end else begin
                            Mem_Addr   <= selAddr;
                            Mem_MemOp  <= selOp;
                            Mem_DataIn <= selData;
                            Mem_WrEn   <= selWrEn;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    Mem_WrEn <= 1'b0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    rspData  <= curWrEn ? 32'h0 : Mem_DataOut;
                    rspErr   <= 1'b0;
                    rspValid <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (owner ? P1_RspReady : P0_RspReady) begin
                        rspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign P0_RspValid = rspValid && !owner;
    assign P1_RspValid = rspValid && owner;
    assign P0_RspData  = owner ? 32'h0 : rspData;
    assign P1_RspData  = owner ? rspData : 32'h0;
    assign P0_RspErr   = !owner && rspErr;
    assign P1_RspErr   = owner && rspErr;
    assign Busy        = !isIdle;

endmodule
